// File: rtl/tinysat_loader.sv
// tinysat_loader: buffers 16 three-literal clauses, replays them into the solver
// in transposed nibble order, runs it with a timeout and returns one result.
//   clk, reset                       clock and synchronous active-high reset
//   cl_valid/cl_ready/cl_data        clause input stream {lit3, lit2, lit1}
//   sat_reset/sat_load/sat_run/sat_data   solver control and load nibble
//   sat_x/sat_sol/sat_done           solver outcome
//   res_valid/res_ready/res_sat/res_x/res_timeout   result stream
//   busy                             high whenever a problem is in flight
module tinysat_loader #(
   parameter int NUM_CLAUSES    = 16,
   parameter int LIT_W          = 4,
   parameter int NUM_BITS       = 4,
   parameter int TIMEOUT_CYCLES = 300
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cl_valid,
   output logic                 cl_ready,
   input  logic [3*LIT_W-1:0]   cl_data,
   output logic                 sat_reset,
   output logic                 sat_load,
   output logic                 sat_run,
   output logic [LIT_W-1:0]     sat_data,
   input  logic [NUM_BITS-1:0]  sat_x,
   input  logic                 sat_sol,
   input  logic                 sat_done,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic                 res_sat,
   output logic [NUM_BITS-1:0]  res_x,
   output logic                 res_timeout,
   output logic                 busy
);
   localparam int CW = $clog2(NUM_CLAUSES);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] SRST   = 3'd1;
   localparam logic [2:0] LOAD   = 3'd2;
   localparam logic [2:0] RUN    = 3'd3;
   localparam logic [2:0] SETTLE = 3'd4;
   localparam logic [2:0] RESULT = 3'd5;

   logic [2:0]          state, state_nx;
   logic [CW:0]         clause_cnt;
   logic [CW+1:0]       ld_cnt;
   logic [TW-1:0]       run_cnt;
   logic [3*LIT_W-1:0]  mem [NUM_CLAUSES];
   logic [3*LIT_W-1:0]  word;
   logic [1:0]          bank;
   logic                accept, last_run;

   assign accept    = cl_valid & cl_ready;
   assign last_run  = run_cnt == TW'(TIMEOUT_CYCLES - 1);
   assign cl_ready  = state == IDLE && !clause_cnt[CW];
   assign sat_load  = state == LOAD;
   assign sat_run   = state == RUN;
   assign res_valid = state == RESULT;
   assign busy      = state != IDLE;

   // ld_cnt walks bank-major: 16 dummy slots, then lit1, lit2, lit3 of every clause
   assign bank = ld_cnt[CW+1:CW];
   assign word = mem[ld_cnt[CW-1:0]];
   assign sat_data = !sat_load ? '0 :
                     bank == 2'd1 ? word[LIT_W-1:0] :
                     bank == 2'd2 ? word[2*LIT_W-1:LIT_W] :
                     bank == 2'd3 ? word[3*LIT_W-1:2*LIT_W] : '0;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept && clause_cnt[CW-1:0] == CW'(NUM_CLAUSES - 1)) state_nx = SRST;
         SRST:    state_nx = LOAD;
         LOAD:    if (&ld_cnt) state_nx = RUN;
         RUN:     state_nx = sat_done ? SETTLE : last_run ? RESULT : RUN;
         SETTLE:  state_nx = RESULT;
         RESULT:  if (res_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         clause_cnt  <= '0;
         ld_cnt      <= '0;
         run_cnt     <= '0;
         sat_reset   <= 1'b1;
         res_sat     <= 1'b0;
         res_x       <= '0;
         res_timeout <= 1'b0;
      end else begin
         state     <= state_nx;
         sat_reset <= state_nx == SRST;
         ld_cnt    <= sat_load ? ld_cnt + 1'b1 : '0;
         run_cnt   <= sat_run ? run_cnt + 1'b1 : '0;
         if (accept) clause_cnt <= clause_cnt + 1'b1;
         if (res_valid && res_ready) clause_cnt <= '0;
         if (sat_run && !sat_done && last_run) begin
            res_sat     <= 1'b0;
            res_x       <= '0;
            res_timeout <= 1'b1;
         end
         // sample the solver one cycle after done, once run has dropped
         if (state == SETTLE) begin
            res_sat     <= sat_sol;
            res_x       <= sat_x;
            res_timeout <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk)
      if (accept) mem[clause_cnt[CW-1:0]] <= cl_data;
endmodule

// File: tb/tb_tinysat_loader.sv
// tb_tinysat_loader: directed bench for tinysat_loader with a simple solver model.
module tb_tinysat_loader;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cl_valid = 1'b0;
   logic        cl_ready;
   logic [11:0] cl_data = '0;
   logic        sat_reset, sat_load, sat_run;
   logic [3:0]  sat_data;
   logic [3:0]  sat_x = '0;
   logic        sat_sol = 1'b0;
   logic        sat_done;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic        res_sat;
   logic [3:0]  res_x;
   logic        res_timeout;
   logic        busy;
   logic        done_mode = 1'b0;
   int          rcnt = 0;
   int          total = 0;
   int          passed = 0;

   tinysat_loader dut (
      .clk(clk), .reset(reset), .cl_valid(cl_valid), .cl_ready(cl_ready), .cl_data(cl_data),
      .sat_reset(sat_reset), .sat_load(sat_load), .sat_run(sat_run), .sat_data(sat_data),
      .sat_x(sat_x), .sat_sol(sat_sol), .sat_done(sat_done),
      .res_valid(res_valid), .res_ready(res_ready), .res_sat(res_sat), .res_x(res_x),
      .res_timeout(res_timeout), .busy(busy)
   );

   always #5 clk = ~clk;

   // solver model: counts run cycles since its reset, raises done at 40 when enabled
   always @(posedge clk)
      if (sat_reset) rcnt <= 0;
      else if (sat_run) rcnt <= rcnt + 1;
   assign sat_done = done_mode && rcnt >= 40;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      else passed++;
   endtask

   // feeds clause k = {k+2, k+1, k}; returns at the negedge after the 16th accept
   task automatic send_clauses(input bit gaps);
      int k = 0;
      int guard = 0;
      logic v, acc;
      while (k < 16 && guard < 200) begin
         @(negedge clk);
         v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         cl_valid = v;
         cl_data = {4'(k + 2), 4'(k + 1), 4'(k)};
         acc = v && cl_ready;
         @(posedge clk);
         if (acc) k++;
         guard++;
      end
      @(negedge clk);
      cl_valid = 1'b0;
      chk("accept16", 32'(k), 32'd16);
   endtask

   // entered at the SRST cycle; leaves at the first RUN cycle
   task automatic check_load;
      logic [3:0] exp;
      chk("srst", 32'({sat_reset, sat_load, sat_run, busy}), 32'b1001);
      for (int c = 0; c < 64; c++) begin
         @(negedge clk);
         exp = c < 16 ? 4'd0 : 4'(c % 16 + c / 16 - 1);
         chk($sformatf("load%0d", c), 32'({sat_load, sat_run, sat_reset, sat_data}), 32'({3'b100, exp}));
      end
      @(negedge clk);
      chk("run_start", 32'({sat_load, sat_run}), 32'b01);
   endtask

   task automatic count_run(output int n);
      n = 0;
      while (sat_run && n < 400) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic take_result;
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("back_idle", 32'({cl_ready, res_valid, busy}), 32'b100);
   endtask

   int n;

   initial begin
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("rst_ctl", 32'({sat_reset, sat_load, sat_run, sat_data}), 32'({3'b100, 4'd0}));
      chk("rst_res", 32'({res_valid, res_sat, res_x, res_timeout}), 32'd0);
      chk("rst_hs", 32'({cl_ready, busy}), 32'b10);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_srst", 32'({sat_reset, cl_ready}), 32'b01);

      // problem 1: solver finishes, result held off for 5 cycles
      done_mode = 1'b1;
      sat_x = 4'hA;
      sat_sol = 1'b1;
      send_clauses(1'b0);
      check_load();
      count_run(n);
      chk("done_runs", 32'(n), 32'd41);
      chk("settle", 32'({sat_run, res_valid, busy}), 32'b001);
      @(negedge clk);
      chk("res_done", 32'({res_valid, res_sat, res_x, res_timeout}), 32'({1'b1, 1'b1, 4'hA, 1'b0}));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold", 32'({res_valid, res_sat, res_x, res_timeout, cl_ready}), 32'({1'b1, 1'b1, 4'hA, 1'b0, 1'b0}));
      end
      take_result();

      // problem 2: gapped input, solver never finishes
      done_mode = 1'b0;
      sat_x = 4'hF;
      send_clauses(1'b1);
      check_load();
      count_run(n);
      chk("to_runs", 32'(n), 32'd300);
      chk("res_to", 32'({res_valid, res_sat, res_x, res_timeout}), 32'({1'b1, 1'b0, 4'h0, 1'b1}));
      take_result();

      // problem 3: reset in the middle of LOAD, then a clean reload
      send_clauses(1'b0);
      for (int i = 0; i < 31; i++) @(negedge clk);
      chk("ld30", 32'({sat_load, sat_data}), 32'({1'b1, 4'hE}));
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst", 32'({sat_load, sat_reset, busy, cl_ready, sat_run}), 32'b01010);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst", 32'({sat_reset, cl_ready, busy}), 32'b010);
      done_mode = 1'b1;
      sat_x = 4'h5;
      send_clauses(1'b0);
      check_load();
      count_run(n);
      chk("done_runs2", 32'(n), 32'd41);
      @(negedge clk);
      chk("res_done2", 32'({res_valid, res_sat, res_x, res_timeout}), 32'({1'b1, 1'b1, 4'h5, 1'b0}));
      take_result();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
